// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: sink side of a 640x480 VGA link. Recovers pixel
// coordinates from hsync/vsync, checks sync timing, locks to the frame and
// captures the colour at a programmable probe pixel once per frame.
// Every output is registered and describes the sample taken one dclk earlier.
module vga_sync_receiver #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HPULSE      = 96,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [2:0] blue_in,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_active,
  output logic       frame_start,
  output logic       locked,
  output logic [8:0] probe_rgb,
  output logic       probe_valid,
  output logic [7:0] err_count
);

  // Counter values seen on the last sample of a correct line / pulse / frame.
  localparam logic [9:0] H_LAST   = 10'(HPIXELS - 1);
  localparam logic [9:0] HP_LAST  = 10'(HPULSE - 1);
  localparam logic [9:0] V_LAST   = 10'(VLINES - 1);
  localparam logic [9:0] VP_LINES = 10'(VPULSE);
  localparam logic [9:0] H_BP     = 10'(HBP);
  localparam logic [9:0] H_FP     = 10'(HFP);
  localparam logic [9:0] V_BP     = 10'(VBP);
  localparam logic [9:0] V_FP     = 10'(VFP);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [7:0] ERR_MAX  = 8'd255;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       hs_prev_q, vs_prev_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0] good_q, good_d;
  logic [7:0] err_q, err_d;
  logic [9:0] px_lat_q, px_lat_d, py_lat_q, py_lat_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic       active_q, active_d;
  logic       fstart_q, fstart_d;
  logic       locked_q, locked_d;
  logic [8:0] rgb_q, rgb_d;
  logic       pvalid_q, pvalid_d;

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic e1, e2, e3, e4, e5, count_err, hit;

  // Edge detection, position counters and timing-error detection.
  always_comb begin
    hs_fall = hs_prev_q & ~hsync_in;
    hs_rise = ~hs_prev_q & hsync_in;
    vs_fall = vs_prev_q & ~vsync_in;
    vs_rise = ~vs_prev_q & vsync_in;
    hcnt_d  = hs_fall ? 10'd0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
    vcnt_d  = vs_fall ? 10'd0 :
              ((hs_fall && (vcnt_q != CNT_MAX)) ? vcnt_q + 10'd1 : vcnt_q);
    e1 = hs_fall && (hcnt_q != H_LAST);   // previous line length
    e2 = hs_rise && (hcnt_q != HP_LAST);  // hsync low width
    e3 = vs_fall && !hs_fall;             // vsync not aligned to line start
    e4 = vs_fall && (vcnt_q != V_LAST);   // previous frame line count
    e5 = vs_rise && (vcnt_d != VP_LINES); // vsync low width in lines
    // Errors only matter once we have started following a frame.
    count_err = (e1 | e2 | e3 | e4 | e5) && (state_q != SEARCH);
    err_d = (count_err && (err_q != ERR_MAX)) ? err_q + 8'd1 : err_q;
  end

  // Lock FSM: next state and good-frame counter.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = TRACK;
          good_d  = 8'd0;
        end else begin
          state_d = SEARCH;
        end
      end
      TRACK: begin
        if (count_err) begin
          state_d = SEARCH;
        end else if (vs_fall) begin
          good_d  = good_q + 8'd1;
          state_d = ((good_q + 8'd1) >= LOCK_N) ? LOCKED : TRACK;
        end else begin
          state_d = TRACK;
        end
      end
      LOCKED: begin
        if (count_err) begin
          state_d = SEARCH;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = 8'd0;
      end
    endcase
  end

  // Output values for the sample being taken, including the probe capture.
  always_comb begin
    locked_d = (state_d == LOCKED);
    active_d = locked_d && (hcnt_d >= H_BP) && (hcnt_d < H_FP) &&
               (vcnt_d >= V_BP) && (vcnt_d < V_FP);
    pix_x_d  = active_d ? hcnt_d - H_BP : 10'd0;
    pix_y_d  = active_d ? vcnt_d - V_BP : 10'd0;
    fstart_d = vs_fall && (state_q != SEARCH);
    // Probe coordinates only change at a frame boundary.
    px_lat_d = fstart_d ? probe_x : px_lat_q;
    py_lat_d = fstart_d ? probe_y : py_lat_q;
    hit      = active_d && (pix_x_d == px_lat_q) && (pix_y_d == py_lat_q);
    rgb_d    = hit ? {red_in, green_in, blue_in} : rgb_q;
    pvalid_d = hit;
  end

  // State register with synchronous clear.
  always_ff @(posedge dclk) begin
    if (clr) begin
      state_q   <= SEARCH;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hcnt_q    <= 10'd0;
      vcnt_q    <= 10'd0;
      good_q    <= 8'd0;
      err_q     <= 8'd0;
      px_lat_q  <= 10'd0;
      py_lat_q  <= 10'd0;
      pix_x_q   <= 10'd0;
      pix_y_q   <= 10'd0;
      active_q  <= 1'b0;
      fstart_q  <= 1'b0;
      locked_q  <= 1'b0;
      rgb_q     <= 9'd0;
      pvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_prev_q <= hsync_in;
      vs_prev_q <= vsync_in;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      good_q    <= good_d;
      err_q     <= err_d;
      px_lat_q  <= px_lat_d;
      py_lat_q  <= py_lat_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      active_q  <= active_d;
      fstart_q  <= fstart_d;
      locked_q  <= locked_d;
      rgb_q     <= rgb_d;
      pvalid_q  <= pvalid_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_active  = active_q;
  assign frame_start = fstart_q;
  assign locked      = locked_q;
  assign probe_rgb   = rgb_q;
  assign probe_valid = pvalid_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Testbench for vga_sync_receiver using a reduced frame geometry
// (40 clocks x 20 lines) so that several frames fit in a short run.
module tb_vga_sync_receiver;

  localparam int HP = 40, VL = 20, HPW = 4, VPW = 2;
  localparam int HBPc = 8, HFPc = 36, VBPc = 3, VFPc = 18, LOCKN = 2;
  localparam int F_NONE = 0, F_SHORT_LINE = 1, F_SHORT_HPULSE = 2, F_VS_LATE = 3, F_LONG_VS = 4;

  logic       dclk = 1'b0;
  logic       clr, hsync_in, vsync_in;
  logic [2:0] red_in, green_in, blue_in;
  logic [9:0] probe_x, probe_y;
  logic [9:0] pix_x, pix_y;
  logic       pix_active, frame_start, locked, probe_valid;
  logic [8:0] probe_rgb;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPW), .VPULSE(VPW),
    .HBP(HBPc), .HFP(HFPc), .VBP(VBPc), .VFP(VFPc), .LOCK_FRAMES(LOCKN)
  ) dut (
    .dclk(dclk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .probe_x(probe_x), .probe_y(probe_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .frame_start(frame_start), .locked(locked), .probe_rgb(probe_rgb),
    .probe_valid(probe_valid), .err_count(err_count)
  );

  always #20 dclk = ~dclk;

  int n_checks = 0;
  int n_fail   = 0;
  int hits     = 0;
  int fs_cnt   = 0;
  int exp_err  = 0;
  bit rand_rgb = 1'b0;

  // Reference model state: timestamps and event counts rather than counters.
  int         n = 0;        // sample index
  int         m_thf;        // sample index of the last line start (or clear)
  int         m_hf;         // line starts since the last frame start
  bit         m_hp, m_vp;
  int         m_mode;       // 0 search, 1 track, 2 locked
  int         m_good, m_err, m_pxl, m_pyl;
  logic [8:0] m_rgb;
  logic [40:0] m_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] dut_vec();
    return {pix_x, pix_y, pix_active, frame_start, locked, probe_rgb, probe_valid, err_count};
  endfunction

  task automatic model_step();
    bit hf, hr, vf, vr, err, fs, pv, act, lk;
    int h, v, px, py;
    n++;
    if (clr) begin
      m_hp = 1'b0; m_vp = 1'b0; m_thf = n; m_hf = 0; m_mode = 0; m_good = 0;
      m_err = 0; m_pxl = 0; m_pyl = 0; m_rgb = 9'd0; m_vec = '0;
    end else begin
      hf = m_hp && !hsync_in;
      hr = !m_hp && hsync_in;
      vf = m_vp && !vsync_in;
      vr = !m_vp && vsync_in;
      err = 1'b0;
      if (hf && (n - m_thf) != HP) err = 1'b1;
      if (hr && (n - m_thf) != HPW) err = 1'b1;
      if (vf && !hf) err = 1'b1;
      if (vf && (m_hf + 1) != VL) err = 1'b1;
      if (hf) begin m_hf++; m_thf = n; end
      if (vf) m_hf = 0;
      if (vr && m_hf != VPW) err = 1'b1;
      m_hp = hsync_in;
      m_vp = vsync_in;
      fs = vf && (m_mode != 0);
      if (m_mode != 0 && err) begin
        if (m_err < 255) m_err++;
        m_mode = 0;
      end else if (vf) begin
        if (m_mode == 0) begin
          m_mode = 1; m_good = 0;
        end else if (m_mode == 1) begin
          m_good++;
          if (m_good >= LOCKN) m_mode = 2;
        end
      end
      h = n - m_thf; if (h > 1023) h = 1023;
      v = (m_hf > 1023) ? 1023 : m_hf;
      lk  = (m_mode == 2);
      act = lk && h >= HBPc && h < HFPc && v >= VBPc && v < VFPc;
      px  = act ? h - HBPc : 0;
      py  = act ? v - VBPc : 0;
      pv  = act && px == m_pxl && py == m_pyl;
      if (pv) m_rgb = {red_in, green_in, blue_in};
      if (fs) begin m_pxl = int'(probe_x); m_pyl = int'(probe_y); end
      m_vec = {10'(px), 10'(py), act, fs, lk, m_rgb, pv, 8'(m_err)};
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
    model_step();
    check("cycle", 64'(dut_vec()), 64'(m_vec));
    hits   += int'(probe_valid);
    fs_cnt += int'(frame_start);
  endtask

  // Drives one frame from line start_vc; clr pulses at (clr_vc, hc=1),
  // probe_x is forced to 0 at (chg_vc, hc=0).
  task automatic gen_frame(input int fault, input int fline, input int start_vc,
                           input bit bounds, input int clr_vc, input int chg_vc);
    for (int vc = start_vc; vc < VL; vc++) begin
      int len, hw, vw;
      len = (fault == F_SHORT_LINE && vc == fline) ? HP - 1 : HP;
      hw  = (fault == F_SHORT_HPULSE && vc == fline) ? HPW - 1 : HPW;
      vw  = (fault == F_LONG_VS) ? VPW + 1 : VPW;
      for (int hc = 0; hc < len; hc++) begin
        hsync_in = (hc >= hw);
        vsync_in = !((vc < vw) && !(fault == F_VS_LATE && vc == 0 && hc < 5));
        if (rand_rgb) {red_in, green_in, blue_in} = 9'($urandom);
        else          {red_in, green_in, blue_in} = 9'(hc * 5 + vc * 17);
        clr = (vc == clr_vc && hc == 1);
        if (vc == chg_vc && hc == 0) probe_x = 10'd0;
        tick();
        if (vc == clr_vc && hc == 1) check("clr_zero", 64'(dut_vec()), 64'd0);
        if (bounds) begin
          if (hc == HBPc && vc == VBPc) begin
            check("bnd_first_x", 64'(pix_x), 64'd0);
            check("bnd_first_y", 64'(pix_y), 64'd0);
            check("bnd_first_act", 64'(pix_active), 64'd1);
          end else if (hc == HFPc - 1 && vc == VFPc - 1) begin
            check("bnd_last_x", 64'(pix_x), 64'd27);
            check("bnd_last_y", 64'(pix_y), 64'd14);
          end else if (hc == HFPc && vc == VFPc - 1) begin
            check("bnd_after_act", 64'(pix_active), 64'd0);
            check("bnd_after_x", 64'(pix_x), 64'd0);
          end
        end
      end
    end
    clr = 1'b0;
  endtask

  typedef struct {
    int fault; int fline; int px; int py;
    int exp_hits; int exp_rgb; int exp_err_inc; bit exp_locked;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{F_NONE,         0, 0,  0,  1, 91,  0, 1'b1};
    tbl[1] = '{F_NONE,         0, 27, 14, 1, 464, 0, 1'b1};
    tbl[2] = '{F_NONE,         0, 28, 0,  0, 0,   0, 1'b1};
    tbl[3] = '{F_NONE,         0, 0,  15, 0, 0,   0, 1'b1};
    tbl[4] = '{F_SHORT_LINE,   5, 0,  0,  1, 91,  1, 1'b0};
    tbl[5] = '{F_SHORT_HPULSE, 5, 12, 1,  1, 168, 1, 1'b0};
    tbl[6] = '{F_VS_LATE,      0, 0,  0,  0, 0,   1, 1'b0};
    tbl[7] = '{F_LONG_VS,      0, 0,  0,  0, 0,   1, 1'b0};

    clr = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    {red_in, green_in, blue_in} = 9'd0;
    probe_x = 10'd0; probe_y = 10'd0;
    repeat (3) tick();
    check("reset_out", 64'(dut_vec()), 64'd0);
    clr = 1'b0;

    // Acquire lock: partial frame, then three vsync falling edges.
    gen_frame(F_NONE, 0, 10, 1'b0, -1, -1);
    check("search_locked", 64'(locked), 64'd0);
    gen_frame(F_NONE, 0, 0, 1'b0, -1, -1);
    fs_cnt = 0;
    gen_frame(F_NONE, 0, 0, 1'b0, -1, -1);
    check("lock_early", 64'(locked), 64'd0);
    check("fs_track", 64'(fs_cnt), 64'd1);
    fs_cnt = 0;
    gen_frame(F_NONE, 0, 0, 1'b1, -1, -1);
    check("lock_done", 64'(locked), 64'd1);
    check("fs_locked", 64'(fs_cnt), 64'd1);
    check("lock_err", 64'(err_count), 64'd0);

    // Table of frame scenarios, each starting from lock.
    for (int i = 0; i < 8; i++) begin
      probe_x = 10'(tbl[i].px);
      probe_y = 10'(tbl[i].py);
      hits = 0;
      gen_frame(tbl[i].fault, tbl[i].fline, 0, 1'b0, -1, -1);
      exp_err += tbl[i].exp_err_inc;
      check("tbl_hits", 64'(hits), 64'(tbl[i].exp_hits));
      if (tbl[i].exp_hits > 0) check("tbl_rgb", 64'(probe_rgb), 64'(tbl[i].exp_rgb));
      check("tbl_err", 64'(err_count), 64'(exp_err));
      check("tbl_locked", 64'(locked), 64'(tbl[i].exp_locked));
      if (!tbl[i].exp_locked) begin
        repeat (3) gen_frame(F_NONE, 0, 0, 1'b0, -1, -1);
        check("relock", 64'(locked), 64'd1);
        check("relock_err", 64'(err_count), 64'(exp_err));
      end
    end

    // Probe change mid-frame takes effect in the following frame.
    probe_x = 10'd20; probe_y = 10'd10; hits = 0;
    gen_frame(F_NONE, 0, 0, 1'b0, -1, 5);
    check("midchg_hits", 64'(hits), 64'd1);
    check("midchg_rgb", 64'(probe_rgb), 64'd361);
    hits = 0;
    gen_frame(F_NONE, 0, 0, 1'b0, -1, -1);
    check("nextfrm_hits", 64'(hits), 64'd1);
    check("nextfrm_rgb", 64'(probe_rgb), 64'd261);

    // Clear mid-frame while hsync is low, then a timing fault while searching.
    gen_frame(F_SHORT_HPULSE, 12, 0, 1'b0, 8, -1);
    check("search_err", 64'(err_count), 64'd0);
    check("search_locked2", 64'(locked), 64'd0);
    exp_err = 0;
    repeat (3) gen_frame(F_NONE, 0, 0, 1'b0, -1, -1);
    check("clr_relock", 64'(locked), 64'd1);
    check("clr_relock_err", 64'(err_count), 64'd0);

    // Randomized frames checked cycle by cycle against the model.
    rand_rgb = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int fk, fl, cv, pc;
      probe_x = 10'($urandom_range(0, 31));
      probe_y = 10'($urandom_range(0, 17));
      fk = ($urandom_range(0, 9) < 6) ? F_NONE : int'($urandom_range(1, 4));
      fl = int'($urandom_range(0, VL - 1));
      cv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, VL - 1)) : -1;
      pc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VL - 1)) : -1;
      gen_frame(fk, fl, 0, 1'b0, cv, pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
